// File: rtl/seq_normalizer.sv
// Iterative normalizer: shifts an operand one bit per clock toward the chosen end
// until that end bit is 1, then reports the normalized word and the shift count.
module seq_normalizer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic             choice,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic [AMT_W-1:0] amt,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic             dir, dir_nx;
    logic [AMT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] y_nx;
    logic [AMT_W-1:0] amt_nx;
    logic             zero_nx;
    logic             hit;

    assign hit   = dir ? work[0] : work[WIDTH-1];
    assign ready = (state == IDLE);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            dir   <= 1'b0;
            cnt   <= '0;
            y     <= '0;
            amt   <= '0;
            zero  <= 1'b0;
        end else begin
            state <= state_nx;
            work  <= work_nx;
            dir   <= dir_nx;
            cnt   <= cnt_nx;
            y     <= y_nx;
            amt   <= amt_nx;
            zero  <= zero_nx;
        end
    end

    always_comb begin
        state_nx = state;
        work_nx  = work;
        dir_nx   = dir;
        cnt_nx   = cnt;
        y_nx     = y;
        amt_nx   = amt;
        zero_nx  = zero;
        case (state)
            IDLE: begin
                if (start) begin
                    work_nx = a;
                    dir_nx  = choice;
                    cnt_nx  = '0;
                    // An all-zero operand never reaches a target bit, so it skips SHIFT.
                    if (a == '0) begin
                        state_nx = DONE;
                        y_nx     = '0;
                        amt_nx   = '0;
                        zero_nx  = 1'b1;
                    end else begin
                        state_nx = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (hit) begin
                    state_nx = DONE;
                    y_nx     = work;
                    amt_nx   = cnt;
                    zero_nx  = 1'b0;
                end else begin
                    // Nonzero operand reaches the target within WIDTH-1 shifts: cnt cannot wrap.
                    work_nx = dir ? (work >> 1) : (work << 1);
                    cnt_nx  = cnt + AMT_W'(1);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_normalizer.sv
// Scoreboard bench for seq_normalizer: stimulus pushes expected results,
// a negedge monitor pops and compares on each done pulse.
module tb_seq_normalizer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a;
    logic       choice;
    logic       ready;
    logic       done;
    logic [7:0] y;
    logic [2:0] amt;
    logic       zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] y;
        logic [2:0] amt;
        logic       zero;
        int         lat;
        int         acc;
        string      name;
    } exp_t;

    exp_t q[$];

    seq_normalizer #(.WIDTH(8), .AMT_W(3)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a      (a),
        .choice (choice),
        .ready  (ready),
        .done   (done),
        .y      (y),
        .amt    (amt),
        .zero   (zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_y"}, int'(y), int'(e.y));
                check({e.name, "_amt"}, int'(amt), int'(e.amt));
                check({e.name, "_zero"}, int'(zero), int'(e.zero));
                check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    // Returns in cycle 1 (the period after the accepting edge).
    task automatic issue(input string name, input logic [7:0] op, input logic ch,
                         input logic [7:0] ey, input logic [2:0] eamt,
                         input logic ez, input int lat);
        exp_t e;
        wait_ready();
        a      = op;
        choice = ch;
        start  = 1'b1;
        @(posedge clk);
        #1;
        e.y = ey; e.amt = eamt; e.zero = ez; e.lat = lat; e.acc = cyc; e.name = name;
        q.push_back(e);
        start = 1'b0;
        a     = 8'hA5;
        choice = ~ch;
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        choice = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_ready", int'(ready), 1);
        check("rst_done", int'(done), 0);
        check("rst_y", int'(y), 0);
        check("rst_amt", int'(amt), 0);
        check("rst_zero", int'(zero), 0);

        // 0x13 left: three shifts; ready low through cycle 5
        issue("l13", 8'h13, 1'b0, 8'h98, 3'd3, 1'b0, 5);
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            else #4;
            check($sformatf("l13_ready_c%0d", k), int'(ready), (k >= 6) ? 1 : 0);
        end

        issue("l80", 8'h80, 1'b0, 8'h80, 3'd0, 1'b0, 2);
        issue("l01", 8'h01, 1'b0, 8'h80, 3'd7, 1'b0, 9);
        issue("z0",  8'h00, 1'b0, 8'h00, 3'd0, 1'b1, 1);
        issue("z1",  8'h00, 1'b1, 8'h00, 3'd0, 1'b1, 1);
        issue("r58", 8'h58, 1'b1, 8'h0B, 3'd3, 1'b0, 5);
        issue("r01", 8'h01, 1'b1, 8'h01, 3'd0, 1'b0, 2);

        // Busy: starts in cycles 1 and 3 ignored; previous result held meanwhile
        issue("l02", 8'h02, 1'b0, 8'h80, 3'd6, 1'b0, 8);
        #4;
        check("hold_y_c1", int'(y), 8'h01);
        check("hold_amt_c1", int'(amt), 0);
        a = 8'hFF; choice = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("hold_y_c3", int'(y), 8'h01);
        a = 8'hFF; choice = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        // Reset in cycle 3 of a 0x01 operation aborts it
        wait_ready();
        a = 8'h01; choice = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_ready", int'(ready), 1);
        check("abort_y", int'(y), 0);
        check("abort_amt", int'(amt), 0);
        check("abort_zero", int'(zero), 0);
        repeat (10) @(negedge clk);
        issue("l40", 8'h40, 1'b0, 8'h80, 3'd1, 1'b0, 3);

        // start coincident with reset is dropped
        wait_ready();
        reset = 1'b1; start = 1'b1; a = 8'h01; choice = 1'b0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        check("rst_start_ready", int'(ready), 1);
        check("rst_start_y", int'(y), 0);
        repeat (12) @(negedge clk);
        check("rst_start_idle", int'(ready), 1);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
